// File: rtl/command_issue_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : command_issue_control_pkg
// Description : Shared types and PSL command constants for the command issue
//               stage.
// Revision    : 1.0
// ============================================================================
package command_issue_control_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_ISSUE = 2'd2
    } cmd_issue_state;

    typedef enum logic [1:0] {
        CMD_INVALID = 2'd0,
        CMD_READ    = 2'd1,
        CMD_WRITE   = 2'd2,
        CMD_WED     = 2'd3
    } command_type;

    // Bookkeeping entry stored per tag so responses can be routed to a CU.
    typedef struct packed {
        logic [7:0]  cu_id;
        command_type cmd_type;
    } CommandTagLine;

    localparam logic [12:0] c_READ_CL_NA = 13'h0A00;
    localparam logic [12:0] c_WRITE_NA   = 13'h0D00;
    localparam logic [2:0]  c_ABT_STRICT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/command_issue_control_if.sv
`default_nettype none
// ============================================================================
// Module      : command_issue_control_if
// Description : Request, tag, response and PSL command bus signals.
// Revision    : 1.0
// ============================================================================
interface command_issue_control_if
    import command_issue_control_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int CREDIT_WIDTH = 9
);
    logic                    enabled_in;
    logic [7:0]              ha_croom;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [12:0]             cmd_command;
    logic [ADDR_WIDTH-1:0]   cmd_address;
    logic [11:0]             cmd_size;
    CommandTagLine           cmd_tag_id;
    logic                    tag_buffer_ready;
    logic [7:0]              command_tag;
    logic                    tag_command_valid;
    CommandTagLine           tag_command_id;
    logic                    response_valid;
    logic signed [8:0]       response_credits;
    logic                    ah_cvalid;
    logic [7:0]              ah_ctag;
    logic                    ah_ctagpar;
    logic [12:0]             ah_com;
    logic                    ah_compar;
    logic [ADDR_WIDTH-1:0]   ah_cea;
    logic                    ah_ceapar;
    logic [11:0]             ah_csize;
    logic [2:0]              ah_cabt;
    logic [CREDIT_WIDTH-1:0] credits_out;
    logic                    credit_overflow;

    modport master (
        output enabled_in, ha_croom, cmd_valid, cmd_command, cmd_address,
               cmd_size, cmd_tag_id, tag_buffer_ready, command_tag,
               response_valid, response_credits,
        input  cmd_ready, tag_command_valid, tag_command_id, ah_cvalid,
               ah_ctag, ah_ctagpar, ah_com, ah_compar, ah_cea, ah_ceapar,
               ah_csize, ah_cabt, credits_out, credit_overflow
    );

    modport slave (
        input  enabled_in, ha_croom, cmd_valid, cmd_command, cmd_address,
               cmd_size, cmd_tag_id, tag_buffer_ready, command_tag,
               response_valid, response_credits,
        output cmd_ready, tag_command_valid, tag_command_id, ah_cvalid,
               ah_ctag, ah_ctagpar, ah_com, ah_compar, ah_cea, ah_ceapar,
               ah_csize, ah_cabt, credits_out, credit_overflow
    );
endinterface
`default_nettype wire

// File: rtl/command_issue_control_parity_odd.sv
`default_nettype none
// ============================================================================
// Module      : parity_odd
// Description : Odd parity bit over a WIDTH-bit field.
// Revision    : 1.0
// ============================================================================
module parity_odd #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_parity
);
    assign o_parity = ~^i_data;
endmodule
`default_nettype wire

// File: rtl/command_issue_control.sv
`default_nettype none
// ============================================================================
// Module      : command_issue_control
// Description : Pairs buffered commands with free tags, gates issue on PSL
//               credits and registers the command onto the ah_c* bus.
// Revision    : 1.0
// ============================================================================
module command_issue_control
    import command_issue_control_pkg::*;
#(
    parameter int CREDIT_WIDTH = 9,
    parameter int ADDR_WIDTH   = 64
) (
    input  wire logic               clock,
    input  wire logic               rst,
    command_issue_control_if.slave  bus
);

    logic                           r_enabled;
    cmd_issue_state                 r_state;
    cmd_issue_state                 w_state_next;
    logic [7:0]                     r_croom;
    logic [7:0]                     w_croom_next;
    logic signed [CREDIT_WIDTH-1:0] r_credits;
    logic signed [CREDIT_WIDTH-1:0] w_credits_next;
    logic signed [CREDIT_WIDTH-1:0] w_credits_sum;
    logic signed [CREDIT_WIDTH-1:0] w_croom_ext;
    logic signed [CREDIT_WIDTH-1:0] w_response;
    logic                           r_overflow;
    logic                           w_overflow_next;
    logic                           w_issue;
    logic                           w_tag_par;
    logic                           w_com_par;
    logic                           w_cea_par;

    logic                           r_cvalid;
    logic [7:0]                     r_ctag;
    logic                           r_ctagpar;
    logic [12:0]                    r_com;
    logic                           r_compar;
    logic [ADDR_WIDTH-1:0]          r_cea;
    logic                           r_ceapar;
    logic [11:0]                    r_csize;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_enabled <= 1'b0;
            r_state   <= CMD_RESET;
        end else begin
            r_enabled <= bus.enabled_in;
            r_state   <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!r_enabled) begin
            w_state_next = CMD_RESET;
        end else begin
            case (r_state)
                CMD_RESET: w_state_next = CMD_LOAD;
                CMD_LOAD:  w_state_next = CMD_ISSUE;
                CMD_ISSUE: w_state_next = CMD_ISSUE;
                default:   w_state_next = CMD_RESET;
            endcase
        end
    end

    // Gate on the registered count only; a same-cycle response cannot unblock issue.
    assign w_issue = (r_state == CMD_ISSUE) && bus.cmd_valid && bus.tag_buffer_ready &&
                     !r_credits[CREDIT_WIDTH-1] && (r_credits != '0);

    assign w_croom_ext   = $signed({{(CREDIT_WIDTH-8){1'b0}}, r_croom});
    assign w_response    = bus.response_valid ? CREDIT_WIDTH'(bus.response_credits) : '0;
    assign w_credits_sum = $signed(r_credits - CREDIT_WIDTH'(w_issue) + w_response);

    always_comb begin
        w_credits_next  = r_credits;
        w_overflow_next = r_overflow;
        w_croom_next    = r_croom;
        if (r_state == CMD_RESET || w_state_next == CMD_RESET) begin
            w_credits_next  = '0;
            w_overflow_next = 1'b0;
        end else if (r_state == CMD_LOAD) begin
            w_croom_next   = bus.ha_croom;
            w_credits_next = $signed({{(CREDIT_WIDTH-8){1'b0}}, bus.ha_croom});
        end else if (w_credits_sum > w_croom_ext) begin
            w_credits_next  = w_croom_ext;
            w_overflow_next = 1'b1;
        end else if (w_credits_sum < $signed(CREDIT_WIDTH'(0))) begin
            w_credits_next  = '0;
            w_overflow_next = 1'b1;
        end else begin
            w_credits_next = w_credits_sum;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_croom    <= '0;
            r_credits  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_croom    <= w_croom_next;
            r_credits  <= w_credits_next;
            r_overflow <= w_overflow_next;
        end
    end

    parity_odd #(.WIDTH(8))          u_tag_par (.i_data(bus.command_tag), .o_parity(w_tag_par));
    parity_odd #(.WIDTH(13))         u_com_par (.i_data(bus.cmd_command), .o_parity(w_com_par));
    parity_odd #(.WIDTH(ADDR_WIDTH)) u_cea_par (.i_data(bus.cmd_address), .o_parity(w_cea_par));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_cvalid  <= 1'b0;
            r_ctag    <= '0;
            r_ctagpar <= 1'b0;
            r_com     <= '0;
            r_compar  <= 1'b0;
            r_cea     <= '0;
            r_ceapar  <= 1'b0;
            r_csize   <= '0;
        end else begin
            r_cvalid <= w_issue;
            if (w_issue) begin
                r_ctag    <= bus.command_tag;
                r_ctagpar <= w_tag_par;
                r_com     <= bus.cmd_command;
                r_compar  <= w_com_par;
                r_cea     <= bus.cmd_address;
                r_ceapar  <= w_cea_par;
                r_csize   <= bus.cmd_size;
            end
        end
    end

    assign bus.cmd_ready         = w_issue;
    assign bus.tag_command_valid = w_issue;
    assign bus.tag_command_id    = bus.cmd_tag_id;
    assign bus.ah_cvalid         = r_cvalid;
    assign bus.ah_ctag           = r_ctag;
    assign bus.ah_ctagpar        = r_ctagpar;
    assign bus.ah_com            = r_com;
    assign bus.ah_compar         = r_compar;
    assign bus.ah_cea            = r_cea;
    assign bus.ah_ceapar         = r_ceapar;
    assign bus.ah_csize          = r_csize;
    assign bus.ah_cabt           = c_ABT_STRICT;
    assign bus.credits_out       = r_credits;
    assign bus.credit_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_command_issue_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_issue_control
// Description : Scenario tasks plus a randomized run against a credit model.
// Revision    : 1.0
// ============================================================================
module tb_command_issue_control;
    import command_issue_control_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    command_issue_control_if #(.ADDR_WIDTH(64), .CREDIT_WIDTH(9)) bus ();

    command_issue_control #(.CREDIT_WIDTH(9), .ADDR_WIDTH(64)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enabled_in       = 1'b0;
        bus.ha_croom         = 8'd0;
        bus.cmd_valid        = 1'b0;
        bus.cmd_command      = 13'd0;
        bus.cmd_address      = 64'd0;
        bus.cmd_size         = 12'd0;
        bus.cmd_tag_id       = '0;
        bus.tag_buffer_ready = 1'b0;
        bus.command_tag      = 8'd0;
        bus.response_valid   = 1'b0;
        bus.response_credits = 9'sd0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Enable takes one cycle to register, then one RESET and one LOAD cycle.
    task automatic bring_up(input int croom);
        bus.ha_croom   = 8'(croom);
        bus.enabled_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.enabled_in       = 1'b1;
        bus.cmd_valid        = 1'b1;
        bus.tag_buffer_ready = 1'b1;
        bus.ha_croom         = 8'd4;
        #23;
        n_checks++;
        if ({bus.cmd_ready, bus.tag_command_valid} !== 2'b00)
            $display("FAIL reset_comb: ready/tagvalid=%b required 00", {bus.cmd_ready, bus.tag_command_valid});
        else n_pass++;
        n_checks++;
        if ({bus.ah_cvalid, bus.ah_ctag, bus.ah_ctagpar, bus.ah_com, bus.ah_compar} !== 23'd0)
            $display("FAIL reset_bus_hi: got %h required 0", {bus.ah_cvalid, bus.ah_ctag, bus.ah_ctagpar, bus.ah_com, bus.ah_compar});
        else n_pass++;
        n_checks++;
        if ({bus.ah_cea, bus.ah_ceapar, bus.ah_csize, bus.ah_cabt} !== 80'd0)
            $display("FAIL reset_bus_lo: got %h required 0", {bus.ah_cea, bus.ah_ceapar, bus.ah_csize, bus.ah_cabt});
        else n_pass++;
        n_checks++;
        if ({bus.credits_out, bus.credit_overflow} !== 10'd0)
            $display("FAIL reset_credits: got %h required 0", {bus.credits_out, bus.credit_overflow});
        else n_pass++;
    endtask

    task automatic test_basic_issue();
        CommandTagLine id;
        pulse_reset();
        bring_up(4);
        id.cu_id    = 8'h3C;
        id.cmd_type = CMD_READ;
        bus.cmd_valid        = 1'b1;
        bus.cmd_command      = c_READ_CL_NA;
        bus.cmd_address      = 64'h1000;
        bus.cmd_size         = 12'd128;
        bus.cmd_tag_id       = id;
        bus.tag_buffer_ready = 1'b1;
        bus.command_tag      = 8'h05;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.tag_command_valid} !== 2'b11)
            $display("FAIL basic_ready: got %b required 11", {bus.cmd_ready, bus.tag_command_valid});
        else n_pass++;
        n_checks++;
        if (bus.tag_command_id !== id)
            $display("FAIL basic_tag_id: got %h required %h", bus.tag_command_id, id);
        else n_pass++;
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({bus.ah_cvalid, bus.ah_ctag, bus.ah_com, bus.ah_csize} !== {1'b1, 8'h05, 13'h0A00, 12'd128})
            $display("FAIL basic_bus: got %h required %h", {bus.ah_cvalid, bus.ah_ctag, bus.ah_com, bus.ah_csize},
                     {1'b1, 8'h05, 13'h0A00, 12'd128});
        else n_pass++;
        n_checks++;
        if (bus.ah_cea !== 64'h1000)
            $display("FAIL basic_cea: got %h required 1000", bus.ah_cea);
        else n_pass++;
        // 0x05 and 0x0A00 hold two ones each, 0x1000 holds one.
        n_checks++;
        if ({bus.ah_ctagpar, bus.ah_compar, bus.ah_ceapar, bus.ah_cabt} !== 6'b110_000)
            $display("FAIL basic_parity: got %b required 110000", {bus.ah_ctagpar, bus.ah_compar, bus.ah_ceapar, bus.ah_cabt});
        else n_pass++;
        n_checks++;
        if (bus.credits_out !== 9'd3)
            $display("FAIL basic_credits: got %0d required 3", bus.credits_out);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.ah_cvalid !== 1'b0)
            $display("FAIL basic_pulse: ah_cvalid=%b required 0", bus.ah_cvalid);
        else n_pass++;
    endtask

    task automatic test_credit_exhaustion();
        int pulses = 0;
        int readies = 0;
        pulse_reset();
        bring_up(2);
        bus.tag_buffer_ready = 1'b1;
        bus.cmd_valid        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.command_tag = 8'(i + 1);
            #1;
            readies += int'(bus.cmd_ready);
            tick();
            pulses += int'(bus.ah_cvalid);
        end
        n_checks++;
        if (pulses !== 2 || readies !== 2)
            $display("FAIL exhaust_count: pulses=%0d ready=%0d required 2 and 2", pulses, readies);
        else n_pass++;
        bus.response_valid   = 1'b1;
        bus.response_credits = 9'sd1;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b0)
            $display("FAIL exhaust_same_cycle: cmd_ready=%b required 0", bus.cmd_ready);
        else n_pass++;
        tick();
        bus.response_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.credits_out !== 9'd1)
            $display("FAIL exhaust_resume: ready=%b credits=%0d required 1 and 1", bus.cmd_ready, bus.credits_out);
        else n_pass++;
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.ah_cvalid !== 1'b1 || bus.ah_ctag !== 8'd3 || bus.credits_out !== 9'd0)
            $display("FAIL exhaust_third: cvalid=%b tag=%0d credits=%0d required 1 3 0",
                     bus.ah_cvalid, bus.ah_ctag, bus.credits_out);
        else n_pass++;
    endtask

    task automatic test_tag_starvation();
        int readies = 0;
        pulse_reset();
        bring_up(4);
        bus.cmd_valid        = 1'b1;
        bus.tag_buffer_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            readies += int'(bus.cmd_ready);
            tick();
        end
        n_checks++;
        if (readies !== 0 || bus.credits_out !== 9'd4 || bus.ah_cvalid !== 1'b0)
            $display("FAIL starve_hold: ready=%0d credits=%0d required 0 and 4", readies, bus.credits_out);
        else n_pass++;
        bus.tag_buffer_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL starve_release: cmd_ready=%b required 1", bus.cmd_ready);
        else n_pass++;
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.credits_out !== 9'd3)
            $display("FAIL starve_credits: got %0d required 3", bus.credits_out);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        bring_up(3);
        bus.cmd_valid        = 1'b1;
        bus.tag_buffer_ready = 1'b1;
        bus.response_valid   = 1'b1;
        bus.response_credits = 9'sd1;
        tick();
        idle_inputs();
        bus.enabled_in = 1'b1;
        bus.ha_croom   = 8'd3;
        n_checks++;
        if (bus.ah_cvalid !== 1'b1 || bus.credits_out !== 9'd3 || bus.credit_overflow !== 1'b0)
            $display("FAIL simul: cvalid=%b credits=%0d ovf=%b required 1 3 0",
                     bus.ah_cvalid, bus.credits_out, bus.credit_overflow);
        else n_pass++;
    endtask

    task automatic test_overflow();
        pulse_reset();
        bring_up(4);
        bus.response_valid   = 1'b1;
        bus.response_credits = 9'sd1;
        tick();
        bus.response_valid = 1'b0;
        n_checks++;
        if (bus.credit_overflow !== 1'b1 || bus.credits_out !== 9'd4)
            $display("FAIL overflow_set: ovf=%b credits=%0d required 1 and 4", bus.credit_overflow, bus.credits_out);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (bus.credit_overflow !== 1'b1)
            $display("FAIL overflow_sticky: ovf=%b required 1", bus.credit_overflow);
        else n_pass++;
        pulse_reset();
        bring_up(4);
        bus.response_valid   = 1'b1;
        bus.response_credits = -9'sd5;
        tick();
        bus.response_valid = 1'b0;
        n_checks++;
        if (bus.credit_overflow !== 1'b1 || bus.credits_out !== 9'd0)
            $display("FAIL underflow: ovf=%b credits=%0d required 1 and 0", bus.credit_overflow, bus.credits_out);
        else n_pass++;
    endtask

    task automatic test_reset_and_disable();
        int readies = 0;
        pulse_reset();
        bring_up(4);
        bus.cmd_valid        = 1'b1;
        bus.tag_buffer_ready = 1'b1;
        bus.command_tag      = 8'h21;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.ah_cvalid, bus.ah_ctag, bus.cmd_ready, bus.credits_out} !== 19'd0)
            $display("FAIL midburst_reset: got %h required 0", {bus.ah_cvalid, bus.ah_ctag, bus.cmd_ready, bus.credits_out});
        else n_pass++;
        tick();
        rst = 1'b0;
        idle_inputs();
        bring_up(4);
        // Issue in the same cycle the enable drops.
        bus.enabled_in       = 1'b0;
        bus.cmd_valid        = 1'b1;
        bus.tag_buffer_ready = 1'b1;
        bus.command_tag      = 8'h44;
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.ah_cvalid !== 1'b1 || bus.ah_ctag !== 8'h44)
            $display("FAIL disable_last_cmd: cvalid=%b tag=%h required 1 44", bus.ah_cvalid, bus.ah_ctag);
        else n_pass++;
        tick();
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            readies += int'(bus.cmd_ready);
            tick();
        end
        n_checks++;
        if (readies !== 0 || bus.credits_out !== 9'd0)
            $display("FAIL disable_idle: ready=%0d credits=%0d required 0 and 0", readies, bus.credits_out);
        else n_pass++;
        bus.cmd_valid = 1'b0;
        bring_up(7);
        n_checks++;
        if (bus.credits_out !== 9'd7)
            $display("FAIL reenable_croom: credits=%0d required 7", bus.credits_out);
        else n_pass++;
    endtask

    task automatic test_random();
        int            cap;
        int            m_credits;
        bit            m_ovf;
        bit            exp_issue;
        int            sum;
        logic [7:0]    e_tag;
        logic [12:0]   e_com;
        logic [63:0]   e_cea;
        logic [11:0]   e_size;
        pulse_reset();
        cap       = int'($urandom_range(1, 8));
        m_credits = cap;
        m_ovf     = 1'b0;
        bring_up(cap);
        for (int cyc = 0; cyc < 300; cyc++) begin
            bus.cmd_valid           = ($urandom_range(0, 9) < 7);
            bus.tag_buffer_ready    = ($urandom_range(0, 3) != 0);
            bus.command_tag         = 8'($urandom);
            bus.cmd_command         = 13'($urandom);
            bus.cmd_address         = {$urandom, $urandom};
            bus.cmd_size            = 12'($urandom);
            bus.cmd_tag_id.cu_id    = 8'($urandom);
            bus.cmd_tag_id.cmd_type = command_type'($urandom_range(0, 3));
            bus.response_valid      = ($urandom_range(0, 9) < 3);
            bus.response_credits    = 9'sd1;
            exp_issue = bus.cmd_valid && bus.tag_buffer_ready && (m_credits > 0);
            e_tag  = bus.command_tag;
            e_com  = bus.cmd_command;
            e_cea  = bus.cmd_address;
            e_size = bus.cmd_size;
            #1;
            n_checks++;
            if (bus.cmd_ready !== exp_issue || bus.tag_command_valid !== exp_issue || bus.tag_command_id !== bus.cmd_tag_id)
                $display("FAIL rand_ready[%0d]: ready=%b tagvalid=%b required %b", cyc, bus.cmd_ready,
                         bus.tag_command_valid, exp_issue);
            else n_pass++;
            sum = m_credits - int'(exp_issue) + (bus.response_valid ? 1 : 0);
            if (sum > cap) begin
                m_credits = cap;
                m_ovf     = 1'b1;
            end else if (sum < 0) begin
                m_credits = 0;
                m_ovf     = 1'b1;
            end else begin
                m_credits = sum;
            end
            tick();
            n_checks++;
            if (bus.ah_cvalid !== exp_issue)
                $display("FAIL rand_cvalid[%0d]: got %b required %b", cyc, bus.ah_cvalid, exp_issue);
            else n_pass++;
            if (exp_issue) begin
                n_checks++;
                if ({bus.ah_ctag, bus.ah_com, bus.ah_cea, bus.ah_csize} !== {e_tag, e_com, e_cea, e_size} ||
                    {bus.ah_ctagpar, bus.ah_compar, bus.ah_ceapar} !== {~^e_tag, ~^e_com, ~^e_cea})
                    $display("FAIL rand_bus[%0d]: tag=%h com=%h cea=%h size=%h par=%b required %h %h %h %h %b",
                             cyc, bus.ah_ctag, bus.ah_com, bus.ah_cea, bus.ah_csize,
                             {bus.ah_ctagpar, bus.ah_compar, bus.ah_ceapar},
                             e_tag, e_com, e_cea, e_size, {~^e_tag, ~^e_com, ~^e_cea});
                else n_pass++;
            end
            n_checks++;
            if (bus.credits_out !== 9'(m_credits) || bus.credit_overflow !== m_ovf)
                $display("FAIL rand_credits[%0d]: credits=%0d ovf=%b required %0d %b", cyc,
                         bus.credits_out, bus.credit_overflow, m_credits, m_ovf);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_credit_exhaustion();
        test_tag_starvation();
        test_simultaneous();
        test_overflow();
        test_reset_and_disable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
